// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to its consumers: coordinates, syncs,
// blanking and frame markers, all registered at the source.
interface vga_timing_gen_if #(
  parameter int H_SIZE = 10,
  parameter int V_SIZE = 10
);
  logic [H_SIZE-1:0] x_addr;
  logic [V_SIZE-1:0] y_addr;
  logic              hsync;
  logic              vsync;
  logic              video_on;
  logic              line_start;
  logic              frame_start;
  logic [7:0]        frame_cnt;

  modport master (
    output x_addr, y_addr, hsync, vsync, video_on, line_start, frame_start, frame_cnt
  );

  modport slave (
    input x_addr, y_addr, hsync, vsync, video_on, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator; every output is a flop that decodes the
// coordinates presented in the same cycle. No backpressure: the raster never stalls.
module vga_timing_gen #(
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   H_SIZE    = 10,
  parameter int   V_SIZE    = 10
) (
  input  logic        pixel_clk,
  input  logic        reset,
  vga_timing_gen_if.master tim_o
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > (1 << H_SIZE)) begin : g_h_size_chk
      $error("vga_timing_gen: H_TOTAL does not fit in H_SIZE bits");
    end
    if (V_TOTAL > (1 << V_SIZE)) begin : g_v_size_chk
      $error("vga_timing_gen: V_TOTAL does not fit in V_SIZE bits");
    end
  endgenerate

  // One extra bit so window ends equal to the total still compare correctly.
  localparam logic [H_SIZE:0] H_LAST   = (H_SIZE+1)'(H_TOTAL - 1);
  localparam logic [H_SIZE:0] H_VIS    = (H_SIZE+1)'(H_DISPLAY);
  localparam logic [H_SIZE:0] HS_START = (H_SIZE+1)'(H_DISPLAY + H_FRONT);
  localparam logic [H_SIZE:0] HS_END   = (H_SIZE+1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [V_SIZE:0] V_LAST   = (V_SIZE+1)'(V_TOTAL - 1);
  localparam logic [V_SIZE:0] V_VIS    = (V_SIZE+1)'(V_DISPLAY);
  localparam logic [V_SIZE:0] VS_START = (V_SIZE+1)'(V_DISPLAY + V_FRONT);
  localparam logic [V_SIZE:0] VS_END   = (V_SIZE+1)'(V_DISPLAY + V_FRONT + V_SYNC);

  logic              run_q;
  logic [H_SIZE-1:0] x_q, x_d;
  logic [V_SIZE-1:0] y_q, y_d;
  logic [7:0]        frame_cnt_q;
  logic              hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic              hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;
  logic              frame_wrap;
  logic [H_SIZE:0]   x_ext;
  logic [V_SIZE:0]   y_ext;

  // run_q holds the raster at (0,0) for the first cycle after reset release.
  always_comb begin
    x_d        = '0;
    y_d        = '0;
    frame_wrap = 1'b0;
    if (run_q) begin
      if ({1'b0, x_q} == H_LAST) begin
        if ({1'b0, y_q} == V_LAST) begin
          frame_wrap = 1'b1;
        end else begin
          y_d = y_q + V_SIZE'(1);
        end
      end else begin
        x_d = x_q + H_SIZE'(1);
        y_d = y_q;
      end
    end
  end

  always_comb begin
    x_ext         = {1'b0, x_d};
    y_ext         = {1'b0, y_d};
    hsync_d       = ((x_ext >= HS_START) && (x_ext < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((y_ext >= VS_START) && (y_ext < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    video_on_d    = (x_ext < H_VIS) && (y_ext < V_VIS);
    line_start_d  = (x_d == '0);
    frame_start_d = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      run_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_cnt_q   <= 8'd0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign tim_o.x_addr      = x_q;
  assign tim_o.y_addr      = y_q;
  assign tim_o.hsync       = hsync_q;
  assign tim_o.vsync       = vsync_q;
  assign tim_o.video_on    = video_on_q;
  assign tim_o.line_start  = line_start_q;
  assign tim_o.frame_start = frame_start_q;
  assign tim_o.frame_cnt   = frame_cnt_q;

endmodule
